// File: rtl/vid_timing_gen_pkg.sv
// Shared video definitions for the timing generator and the stream-side
// lock checker.
//   vid_mode_t     : one axis of a mode line (active, end of front porch,
//                    end of sync, total), 16 bits per field.
//   vid_pattern_e  : test-pattern select.
//   vid_mode_valid : 0 < width <= front <= sync <= raw.
//   vid_bar_color  : colour of colour-bar k (bar 0 white, bar 7 black).
package vid_timing_gen_pkg;

  localparam int unsigned VID_POS_W = 16;
  localparam int unsigned VID_PIX_W = 24;

  typedef struct packed {
    logic [VID_POS_W-1:0] width;
    logic [VID_POS_W-1:0] front;
    logic [VID_POS_W-1:0] sync;
    logic [VID_POS_W-1:0] raw;
  } vid_mode_t;

  typedef enum logic [1:0] {
    PAT_SOLID    = 2'd0,
    PAT_GRADIENT = 2'd1,
    PAT_CHECKER  = 2'd2,
    PAT_BARS     = 2'd3
  } vid_pattern_e;

  function automatic logic vid_mode_valid(input vid_mode_t m);
    return (m.width != '0) &&
           (m.width <= m.front) &&
           (m.front <= m.sync) &&
           (m.sync  <= m.raw);
  endfunction

  function automatic logic [VID_PIX_W-1:0] vid_bar_color(input logic [2:0] k);
    return {{8{~k[2]}}, {8{~k[1]}}, {8{~k[0]}}};
  endfunction

endpackage

// File: rtl/vid_pattern_gen.sv
// Test-pattern source for the timing generator.
//   i_clk, i_reset : pixel clock, asynchronous active-high reset.
//   i_hpos, i_vpos : current raster counters (vpos low byte only).
//   i_width        : latched active width, sets the colour-bar length.
//   i_pattern      : pattern select (solid/gradient/checker/bars).
//   i_color        : solid colour, RGB 8:8:8.
//   o_pixel        : combinational pixel for the current counters; the
//                    caller registers it and blanks it outside active video.
module vid_pattern_gen
  import vid_timing_gen_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_hpos,
  input  logic [7:0]  i_vpos,
  input  logic [15:0] i_width,
  input  logic [1:0]  i_pattern,
  input  logic [23:0] i_color,
  output logic [23:0] o_pixel
);

  logic [15:0] w_bar_len;
  logic [15:0] r_sub;
  logic [2:0]  r_k;
  logic [15:0] w_sub;
  logic [2:0]  w_k;
  logic [15:0] w_sub_nxt;
  logic [2:0]  w_k_nxt;
  logic [2:0]  w_bar_k;
  logic [7:0]  w_hb;
  logic [7:0]  w_vb;

  assign w_bar_len = i_width >> 3;
  assign w_hb      = i_hpos[7:0];
  assign w_vb      = i_vpos;

  // r_sub/r_k hold the bar state that belongs to the current hpos; at the
  // start of each line they are overridden so a stale value from the
  // previous line (or a previous mode) never leaks into bar 0.
  always_comb begin
    w_sub     = r_sub;
    w_k       = r_k;
    if (i_hpos == 16'd0) begin
      w_sub = 16'd0;
      w_k   = 3'd0;
    end
    w_sub_nxt = w_sub + 16'd1;
    w_k_nxt   = w_k;
    if (w_sub_nxt == w_bar_len) begin
      w_sub_nxt = 16'd0;
      if (w_k != 3'd7) begin
        w_k_nxt = w_k + 3'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sub <= 16'd0;
      r_k   <= 3'd0;
    end else begin
      r_sub <= w_sub_nxt;
      r_k   <= w_k_nxt;
    end
  end

  // Bars narrower than one pixel are impossible, so tiny widths fall back
  // to one bar per pixel.
  assign w_bar_k = (i_width < 16'd8) ? i_hpos[2:0] : w_k;

  always_comb begin
    o_pixel = 24'h000000;
    case (vid_pattern_e'(i_pattern))
      PAT_SOLID:    o_pixel = i_color;
      PAT_GRADIENT: o_pixel = {w_hb, w_vb, w_hb ^ w_vb};
      PAT_CHECKER:  o_pixel = (w_hb[4] ^ w_vb[4]) ? 24'hffffff : 24'h000000;
      PAT_BARS:     o_pixel = vid_bar_color(w_bar_k);
      default:      o_pixel = 24'h000000;
    endcase
  end

endmodule

// File: rtl/vid_timing_gen.sv
// Raster video timing generator with test-pattern pixel source.
//   i_clk, i_reset      : pixel clock, asynchronous active-high reset.
//   i_width..i_raw_width: horizontal mode line (active, end of front porch,
//                         end of sync, total), in pixels.
//   i_height..i_raw_height: vertical mode line, in lines.
//   i_pattern, i_color  : test-pattern select and solid colour.
//   o_pix_valid, o_hsync, o_vsync, o_pixel : timing and pixel outputs,
//                         registered one cycle behind the counters.
//   o_hpos, o_vpos      : raster position of the current output.
//   o_sof               : first active pixel of a frame.
//   o_mode_err          : latched mode is invalid; generator idles.
// The mode line is only sampled at the end of a frame (or continuously
// while the latched mode is invalid), so mid-frame edits never tear a frame.
module vid_timing_gen
  import vid_timing_gen_pkg::*;
#(
  parameter logic OPT_INVERT_HSYNC = 1'b0,
  parameter logic OPT_INVERT_VSYNC = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_width,
  input  logic [15:0] i_hfront,
  input  logic [15:0] i_hsync,
  input  logic [15:0] i_raw_width,
  input  logic [15:0] i_height,
  input  logic [15:0] i_vfront,
  input  logic [15:0] i_vsync,
  input  logic [15:0] i_raw_height,
  input  logic [1:0]  i_pattern,
  input  logic [23:0] i_color,
  output logic        o_pix_valid,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic [23:0] o_pixel,
  output logic [15:0] o_hpos,
  output logic [15:0] o_vpos,
  output logic        o_sof,
  output logic        o_mode_err
);

  vid_mode_t   w_hmode_in;
  vid_mode_t   w_vmode_in;
  vid_mode_t   r_hmode;
  vid_mode_t   r_vmode;
  logic [15:0] r_hcnt;
  logic [15:0] r_vcnt;
  logic        w_mode_ok;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_load;
  logic        w_pix_valid;
  logic        w_hs_act;
  logic        w_vs_act;
  logic        w_sof;
  logic [23:0] w_pat_pixel;

  assign w_hmode_in = {i_width, i_hfront, i_hsync, i_raw_width};
  assign w_vmode_in = {i_height, i_vfront, i_vsync, i_raw_height};

  assign w_mode_ok  = vid_mode_valid(r_hmode) && vid_mode_valid(r_vmode);
  assign o_mode_err = ~w_mode_ok;

  assign w_h_last   = (r_hcnt == (r_hmode.raw - 16'd1));
  assign w_v_last   = (r_vcnt == (r_vmode.raw - 16'd1));

  // While invalid the registers track the inputs every cycle, so a fix to
  // the mode line takes effect on the very next clock.
  assign w_load     = (w_h_last && w_v_last) || !w_mode_ok;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_hmode <= '0;
      r_vmode <= '0;
    end else if (w_load) begin
      r_hmode <= w_hmode_in;
      r_vmode <= w_vmode_in;
    end
  end

  // Counters are pinned at 0 whenever the latched mode is invalid, which
  // also gives the restart at (0,0) when an invalid mode becomes valid.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_hcnt <= 16'd0;
      r_vcnt <= 16'd0;
    end else if (!w_mode_ok) begin
      r_hcnt <= 16'd0;
      r_vcnt <= 16'd0;
    end else if (w_h_last) begin
      r_hcnt <= 16'd0;
      r_vcnt <= w_v_last ? 16'd0 : (r_vcnt + 16'd1);
    end else begin
      r_hcnt <= r_hcnt + 16'd1;
    end
  end

  // Decode of the current counter position.
  always_comb begin
    w_pix_valid = w_mode_ok &&
                  (r_hcnt < r_hmode.width) && (r_vcnt < r_vmode.width);
    w_hs_act    = w_mode_ok &&
                  (r_hcnt >= r_hmode.front) && (r_hcnt < r_hmode.sync);
    w_vs_act    = w_mode_ok &&
                  (r_vcnt >= r_vmode.front) && (r_vcnt < r_vmode.sync);
    w_sof       = w_pix_valid && (r_hcnt == 16'd0) && (r_vcnt == 16'd0);
  end

  vid_pattern_gen u_pattern (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_hpos    (r_hcnt),
    .i_vpos    (r_vcnt[7:0]),
    .i_width   (r_hmode.width),
    .i_pattern (i_pattern),
    .i_color   (i_color),
    .o_pixel   (w_pat_pixel)
  );

  // Output register stage: everything lags the counters by one cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_pix_valid <= 1'b0;
      o_hsync     <= OPT_INVERT_HSYNC;
      o_vsync     <= OPT_INVERT_VSYNC;
      o_pixel     <= 24'h000000;
      o_hpos      <= 16'd0;
      o_vpos      <= 16'd0;
      o_sof       <= 1'b0;
    end else begin
      o_pix_valid <= w_pix_valid;
      o_hsync     <= w_hs_act ^ OPT_INVERT_HSYNC;
      o_vsync     <= w_vs_act ^ OPT_INVERT_VSYNC;
      o_pixel     <= w_pix_valid ? w_pat_pixel : 24'h000000;
      o_hpos      <= r_hcnt;
      o_vpos      <= r_vcnt;
      o_sof       <= w_sof;
    end
  end

endmodule

// File: tb/tb_vid_timing_gen.sv
`timescale 1ns/1ps
module tb_vid_timing_gen;

  localparam logic INV_V = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] width, hfront, hsync, raw_w;
  logic [15:0] height, vfront, vsync, raw_h;
  logic [1:0]  pattern;
  logic [23:0] color;

  logic        o_pix_valid, o_hsync, o_vsync, o_sof, o_mode_err;
  logic [23:0] o_pixel;
  logic [15:0] o_hpos, o_vpos;

  always #5 clk = ~clk;

  vid_timing_gen #(
    .OPT_INVERT_HSYNC (1'b0),
    .OPT_INVERT_VSYNC (INV_V)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_width      (width),
    .i_hfront     (hfront),
    .i_hsync      (hsync),
    .i_raw_width  (raw_w),
    .i_height     (height),
    .i_vfront     (vfront),
    .i_vsync      (vsync),
    .i_raw_height (raw_h),
    .i_pattern    (pattern),
    .i_color      (color),
    .o_pix_valid  (o_pix_valid),
    .o_hsync      (o_hsync),
    .o_vsync      (o_vsync),
    .o_pixel      (o_pixel),
    .o_hpos       (o_hpos),
    .o_vpos       (o_vpos),
    .o_sof        (o_sof),
    .o_mode_err   (o_mode_err)
  );

  typedef struct packed {
    logic        pv;
    logic        hs;
    logic        vs;
    logic        sof;
    logic        err;
    logic [15:0] hpos;
    logic [15:0] vpos;
    logic [23:0] pix;
  } obs_t;

  obs_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: latched mode and raster counters.
  int mh_w, mh_f, mh_s, mh_r;
  int mv_w, mv_f, mv_s, mv_r;
  int m_h, m_v;

  function automatic bit m_ok(int w, int f, int s, int r);
    return (w > 0) && (w <= f) && (f <= s) && (s <= r);
  endfunction

  function automatic logic [23:0] m_pix(int h, int v, int w,
                                        logic [1:0] pat, logic [23:0] col);
    logic [7:0]  hb, vb;
    logic [23:0] px;
    int          k;
    hb = h[7:0];
    vb = v[7:0];
    px = 24'h0;
    case (pat)
      2'd0: px = col;
      2'd1: px = {hb, vb, hb ^ vb};
      2'd2: px = (hb[4] ^ vb[4]) ? 24'hffffff : 24'h000000;
      default: begin
        if (w < 8) k = h % 8;
        else begin
          k = h / (w / 8);
          if (k > 7) k = 7;
        end
        case (k)
          0: px = 24'hffffff;
          1: px = 24'hffff00;
          2: px = 24'hff00ff;
          3: px = 24'hff0000;
          4: px = 24'h00ffff;
          5: px = 24'h00ff00;
          6: px = 24'h0000ff;
          default: px = 24'h000000;
        endcase
      end
    endcase
    return px;
  endfunction

  task automatic model_reset();
    mh_w = 0; mh_f = 0; mh_s = 0; mh_r = 0;
    mv_w = 0; mv_f = 0; mv_s = 0; mv_r = 0;
    m_h = 0; m_v = 0;
    sb.delete();
  endtask

  // Predict what the DUT shows after the coming clock edge, push it, then
  // advance the model and the clock.
  task automatic step();
    obs_t e;
    bit   ok, eof;
    ok     = m_ok(mh_w, mh_f, mh_s, mh_r) && m_ok(mv_w, mv_f, mv_s, mv_r);
    eof    = ok && (m_h == mh_r - 1) && (m_v == mv_r - 1);
    e.pv   = ok && (m_h < mh_w) && (m_v < mv_w);
    e.hs   = ok && (m_h >= mh_f) && (m_h < mh_s);
    e.vs   = (ok && (m_v >= mv_f) && (m_v < mv_s)) ^ INV_V;
    e.sof  = e.pv && (m_h == 0) && (m_v == 0);
    e.hpos = m_h[15:0];
    e.vpos = m_v[15:0];
    e.pix  = e.pv ? m_pix(m_h, m_v, mh_w, pattern, color) : 24'h0;
    if (!ok) begin
      m_h = 0; m_v = 0;
    end else if (m_h == mh_r - 1) begin
      m_h = 0;
      m_v = (m_v == mv_r - 1) ? 0 : m_v + 1;
    end else begin
      m_h = m_h + 1;
    end
    if (!ok || eof) begin
      mh_w = int'(width);  mh_f = int'(hfront); mh_s = int'(hsync);  mh_r = int'(raw_w);
      mv_w = int'(height); mv_f = int'(vfront); mv_s = int'(vsync);  mv_r = int'(raw_h);
    end
    e.err = !(m_ok(mh_w, mh_f, mh_s, mh_r) && m_ok(mv_w, mv_f, mv_s, mv_r));
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.pv   = o_pix_valid;
    o.hs   = o_hsync;
    o.vs   = o_vsync;
    o.sof  = o_sof;
    o.err  = o_mode_err;
    o.hpos = o_hpos;
    o.vpos = o_vpos;
    o.pix  = o_pixel;
    return o;
  endfunction

  task automatic set_mode(int hw, int hf, int hs, int hr,
                          int vw, int vf, int vs, int vr);
    width  = hw[15:0]; hfront = hf[15:0]; hsync = hs[15:0]; raw_w = hr[15:0];
    height = vw[15:0]; vfront = vf[15:0]; vsync = vs[15:0]; raw_h = vr[15:0];
  endtask

  task automatic test_reset();
    set_mode(4, 6, 8, 10, 3, 4, 5, 6);
    pattern = 2'd0;
    color   = 24'h123456;
    rst     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if ({o_pix_valid, o_hsync, o_vsync, o_sof, o_mode_err} !== {1'b0, 1'b0, INV_V, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_flags got pv/hs/vs/sof/err=%b%b%b%b%b exp=00%b01",
               o_pix_valid, o_hsync, o_vsync, o_sof, o_mode_err, INV_V);
    end
    checks++;
    if ({o_pixel, o_hpos, o_vpos} !== 56'h0) begin
      errors++;
      $display("FAIL reset_data got pix=%h hpos=%0d vpos=%0d exp all zero", o_pixel, o_hpos, o_vpos);
    end
  endtask

  task automatic test_release();
    obs_t got, exp;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL release_raster cyc=%0d got=%h exp=%h", i, got, exp);
      end
      if (i == 0) begin
        checks++;
        if (o_mode_err !== 1'b0) begin
          errors++;
          $display("FAIL release_mode_err got=%b exp=0", o_mode_err);
        end
      end else begin
        checks++;
        if ({o_pix_valid, o_sof, o_hpos, o_vpos} !== {1'b1, 1'b1, 32'h0}) begin
          errors++;
          $display("FAIL release_first_pixel got pv=%b sof=%b h=%0d v=%0d exp 1 1 0 0",
                   o_pix_valid, o_sof, o_hpos, o_vpos);
        end
      end
    end
  endtask

  task automatic test_basic_frame();
    obs_t got, exp;
    int n_pv = 0, n_sof = 0, n_hs = 0, n_vs = 0, n_badpix = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL frame_raster cyc=%0d got=%h exp=%h", i, got, exp);
      end
      if (got.pv) n_pv++;
      if (got.pv && got.pix !== 24'h123456) n_badpix++;
      if (got.sof) n_sof++;
      if (got.hs) n_hs++;
      if (got.vs == ~INV_V) n_vs++;
    end
    checks++;
    if (n_pv !== 12) begin errors++; $display("FAIL frame_valid_count got=%0d exp=12", n_pv); end
    checks++;
    if (n_badpix !== 0) begin errors++; $display("FAIL frame_solid_pixels got=%0d wrong exp=0", n_badpix); end
    checks++;
    if (n_sof !== 1) begin errors++; $display("FAIL frame_sof_count got=%0d exp=1", n_sof); end
    checks++;
    if (n_hs !== 12) begin errors++; $display("FAIL frame_hsync_count got=%0d exp=12", n_hs); end
    checks++;
    if (n_vs !== 10) begin errors++; $display("FAIL frame_vsync_count got=%0d exp=10", n_vs); end
  endtask

  task automatic test_width_change();
    obs_t got, exp;
    int n = 0, maxh = 0, n_pv = 0;
    bit seen = 0;
    while (!(m_h == 2 && m_v == 1) && n < 100) begin
      step(); n++;
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL wchg_pre got=%h exp=%h", got, exp); end
    end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL wchg_reach_pos got=timeout exp=(2,1)"); end
    width = 16'd5;
    n = 0;
    while (!seen && n < 100) begin
      step(); n++;
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL wchg_old_frame got=%h exp=%h", got, exp); end
      if (got.sof) seen = 1;
      else if (got.pv && int'(got.hpos) > maxh) maxh = int'(got.hpos);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL wchg_sof got=timeout exp=sof"); end
    checks++;
    if (maxh !== 3) begin errors++; $display("FAIL wchg_old_width got max hpos=%0d exp=3", maxh); end
    if (got.pv) n_pv++;
    for (int i = 0; i < 59; i++) begin
      step();
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL wchg_new_frame got=%h exp=%h", got, exp); end
      if (got.pv) n_pv++;
    end
    checks++;
    if (n_pv !== 15) begin errors++; $display("FAIL wchg_new_count got=%0d exp=15", n_pv); end
  endtask

  task automatic test_invalid_mode();
    obs_t got, exp;
    int n = 0, n_busy = 0;
    hfront = 16'd3;
    while (o_mode_err !== 1'b1 && n < 100) begin
      step(); n++;
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL inv_enter got=%h exp=%h", got, exp); end
    end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL inv_mode_err got=timeout exp=1"); end
    for (int i = 0; i < 20; i++) begin
      step();
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL inv_idle got=%h exp=%h", got, exp); end
      if (got.pv || got.hs || got.hpos != 0 || got.vpos != 0 || !got.err) n_busy++;
    end
    checks++;
    if (n_busy !== 0) begin errors++; $display("FAIL inv_idle_count got=%0d busy exp=0", n_busy); end
    hfront = 16'd6;
    step();
    got = sample(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL inv_restore got=%h exp=%h", got, exp); end
    checks++;
    if (o_mode_err !== 1'b0) begin errors++; $display("FAIL inv_clear got err=%b exp=0", o_mode_err); end
    step();
    got = sample(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL inv_resume got=%h exp=%h", got, exp); end
    checks++;
    if ({o_pix_valid, o_sof, o_hpos, o_vpos} !== {1'b1, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL inv_resume_origin got pv=%b sof=%b h=%0d v=%0d exp 1 1 0 0",
               o_pix_valid, o_sof, o_hpos, o_vpos);
    end
  endtask

  task automatic test_bars();
    obs_t got, exp;
    logic [23:0] bars [8];
    int n = 0;
    bars = '{24'hffffff, 24'hffff00, 24'hff00ff, 24'hff0000,
             24'h00ffff, 24'h00ff00, 24'h0000ff, 24'h000000};
    set_mode(64, 66, 70, 72, 2, 3, 4, 4);
    pattern = 2'd3;
    got = sample();
    while (!(got.sof && got.hpos == 0 && mh_w == 64) && n < 200) begin
      step(); n++;
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL bars_wait got=%h exp=%h", got, exp); end
    end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL bars_sof got=timeout exp=sof"); end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (o_pixel !== bars[i / 8] || o_hpos !== i[15:0]) begin
        errors++;
        $display("FAIL bars_pixel hpos=%0d got=%h exp=%h at hpos %0d", o_hpos, o_pixel, bars[i / 8], i);
      end
      step();
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL bars_raster got=%h exp=%h", got, exp); end
    end
  endtask

  task automatic test_boundaries();
    obs_t got, exp;
    int n = 0, n_pv = 0, n_hs = 0, n_vs = 0;
    set_mode(32, 32, 32, 32, 2, 2, 2, 2);
    pattern = 2'd1;
    got = sample();
    while (!(got.sof && mh_w == 32) && n < 400) begin
      step(); n++;
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL bound_wait got=%h exp=%h", got, exp); end
    end
    checks++;
    if (n >= 400) begin errors++; $display("FAIL bound_sof got=timeout exp=sof"); end
    for (int i = 0; i < 128; i++) begin
      if (i == 64) pattern = 2'd2;
      step();
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL bound_raster cyc=%0d got=%h exp=%h", i, got, exp); end
      if (got.pv) n_pv++;
      if (got.hs) n_hs++;
      if (got.vs == ~INV_V) n_vs++;
    end
    checks++;
    if (n_pv !== 128) begin errors++; $display("FAIL bound_continuous got=%0d exp=128", n_pv); end
    checks++;
    if (n_hs + n_vs !== 0) begin errors++; $display("FAIL bound_zero_sync got=%0d active exp=0", n_hs + n_vs); end
  endtask

  task automatic test_reset_mid();
    obs_t got, exp;
    set_mode(4, 6, 8, 10, 3, 4, 5, 6);
    pattern = 2'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL rmid_pre got=%h exp=%h", got, exp); end
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({o_pix_valid, o_mode_err, o_vsync, o_hpos, o_vpos, o_pixel} !== {1'b0, 1'b1, INV_V, 56'h0}) begin
      errors++;
      $display("FAIL rmid_async got pv=%b err=%b vs=%b h=%0d v=%0d pix=%h exp idle",
               o_pix_valid, o_mode_err, o_vsync, o_hpos, o_vpos, o_pixel);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL rmid_post cyc=%0d got=%h exp=%h", i, got, exp); end
      if (i == 1) begin
        checks++;
        if (o_sof !== 1'b1) begin errors++; $display("FAIL rmid_sof got=%b exp=1", o_sof); end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_release();
    test_basic_frame();
    test_width_change();
    test_invalid_mode();
    test_bars();
    test_boundaries();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
